// File: rtl/elevator_sched.sv
// Collective up/down sweep scheduler for a 4-floor car: IDLE -> MOVE -> ARRIVE -> DOOR.
// Optional macro DOOR_HOLD_EN adds a door_hold input that keeps the door open while asserted.
module elevator_sched #(
  parameter int MOVE_CYCLES = 8,
  parameter int DOOR_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [5:0] calls,
`ifdef DOOR_HOLD_EN
  input  logic       door_hold,
`endif
  output logic [1:0] cur_Floor,
  output logic       ce,
  output logic       door_open,
  output logic       moving,
  output logic       dir_up,
  output logic [1:0] state
);

  localparam int MAX_CYC = (MOVE_CYCLES > DOOR_CYCLES) ? MOVE_CYCLES : DOOR_CYCLES;
  localparam int CW = $clog2(MAX_CYC + 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_MOVE   = 2'd1,
    S_ARRIVE = 2'd2,
    S_DOOR   = 2'd3
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [1:0]    floor_q, floor_d;
  logic          dir_up_q, dir_up_d;
  logic          ce_q, ce_d;
  logic          door_open_q, door_open_d;
  logic          moving_q, moving_d;

  logic [3:0]    req;
  logic          req_here;
  logic          above;
  logic          below;
  logic          hold;

`ifdef DOOR_HOLD_EN
  assign hold = door_hold;
`else
  assign hold = 1'b0;
`endif

  always_comb begin
    req      = {calls[5], calls[3] | calls[4], calls[1] | calls[2], calls[0]};
    req_here = req[floor_q];
    above    = 1'b0;
    below    = 1'b0;
    for (int f = 0; f < 4; f++) begin
      if (2'(f) > floor_q) above = above | req[f];
      if (2'(f) < floor_q) below = below | req[f];
    end
  end

  // State register: rst overrides everything, including a move in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      floor_q     <= 2'd0;
      dir_up_q    <= 1'b1;
      ce_q        <= 1'b0;
      door_open_q <= 1'b0;
      moving_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      floor_q     <= floor_d;
      dir_up_q    <= dir_up_d;
      ce_q        <= ce_d;
      door_open_q <= door_open_d;
      moving_q    <= moving_d;
    end
  end

  // Next-state logic. Leaving ARRIVE/DOOR without serving the current floor
  // keeps the sweep direction if work remains ahead, otherwise reverses.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    floor_d  = floor_q;
    dir_up_d = dir_up_q;
    case (state_q)
      S_IDLE: begin
        if (req_here) begin
          state_d = S_DOOR;
        end else if (above) begin
          dir_up_d = 1'b1;
          state_d  = S_MOVE;
        end else if (below) begin
          dir_up_d = 1'b0;
          state_d  = S_MOVE;
        end
      end
      S_MOVE: begin
        if (cnt_q == CW'(MOVE_CYCLES - 1)) begin
          floor_d = dir_up_q ? floor_q + 2'd1 : floor_q - 2'd1;
          state_d = S_ARRIVE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_ARRIVE, S_DOOR: begin
        if (state_q == S_ARRIVE && req_here) begin
          state_d = S_DOOR;
        end else if (state_q == S_DOOR && hold) begin
          cnt_d = '0;
        end else if (state_q == S_DOOR && cnt_q != CW'(DOOR_CYCLES - 1)) begin
          cnt_d = cnt_q + 1'b1;
        end else if (dir_up_q ? above : below) begin
          state_d = S_MOVE;
        end else if (dir_up_q ? below : above) begin
          dir_up_d = ~dir_up_q;
          state_d  = S_MOVE;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Outputs are decoded from the next state so they are registered with it.
  always_comb begin
    ce_d        = (state_d == S_DOOR);
    door_open_d = (state_d == S_DOOR);
    moving_d    = (state_d == S_MOVE);
  end

  assign cur_Floor = floor_q;
  assign ce        = ce_q;
  assign door_open = door_open_q;
  assign moving    = moving_q;
  assign dir_up    = dir_up_q;
  assign state     = state_q;

endmodule

// File: tb/tb_elevator_sched.sv
// Directed bench for elevator_sched with a simple hall-call latch model that
// clears the calls at cur_Floor on every edge where ce was high.
module tb_elevator_sched;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MOVE   = 2'd1;
  localparam logic [1:0] ST_ARRIVE = 2'd2;
  localparam logic [1:0] ST_DOOR   = 2'd3;

  logic       clk;
  logic       rst;
  logic [5:0] calls;
  logic       door_hold;
  logic [1:0] cur_floor;
  logic       ce;
  logic       door_open;
  logic       moving;
  logic       dir_up;
  logic [1:0] state;

  int checks;
  int failures;

  elevator_sched #(.MOVE_CYCLES(8), .DOOR_CYCLES(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .calls     (calls),
`ifdef DOOR_HOLD_EN
    .door_hold (door_hold),
`endif
    .cur_Floor (cur_floor),
    .ce        (ce),
    .door_open (door_open),
    .moving    (moving),
    .dir_up    (dir_up),
    .state     (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [5:0] floor_mask(input logic [1:0] f);
    case (f)
      2'd0:    floor_mask = 6'b000001;
      2'd1:    floor_mask = 6'b000110;
      2'd2:    floor_mask = 6'b011000;
      default: floor_mask = 6'b100000;
    endcase
  endfunction

  // One clock; the latch drops the served floor's calls if ce was high.
  task automatic step();
    logic       ce_s;
    logic [1:0] fl_s;
    ce_s = ce;
    fl_s = cur_floor;
    @(posedge clk);
    #1;
    if (ce_s) calls = calls & ~floor_mask(fl_s);
  endtask

  task automatic step_n(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_state(input logic [1:0] st, input int max_cyc, output int n);
    n = 0;
    while (state !== st && n < max_cyc) begin
      step();
      n++;
    end
    checks++;
    if (state !== st) begin
      failures++;
      $display("FAIL wait_state timeout: state=%0d required=%0d after %0d cycles", state, st, n);
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    calls = 6'b000000;
    door_hold = 1'b0;
    step_n(2);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    calls = 6'b111111;
    door_hold = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++;
    if (cur_floor !== 2'd0) begin failures++; $display("FAIL reset_floor: got %0d required 0", cur_floor); end
    checks++;
    if (state !== ST_IDLE) begin failures++; $display("FAIL reset_state: got %0d required 0", state); end
    checks++;
    if (dir_up !== 1'b1) begin failures++; $display("FAIL reset_dir: got %0b required 1", dir_up); end
    checks++;
    if ({ce, door_open, moving} !== 3'b000) begin
      failures++; $display("FAIL reset_outputs: got ce/door/moving=%03b required 000", {ce, door_open, moving});
    end
    rst = 1'b0;
    step();
    checks++;
    if (state !== ST_DOOR || ce !== 1'b1 || cur_floor !== 2'd0) begin
      failures++; $display("FAIL reset_release_door: got state=%0d ce=%0b floor=%0d required 3/1/0", state, ce, cur_floor);
    end
    do_reset();
  endtask

  task automatic test_long_up();
    do_reset();
    calls = 6'b100000;
    step();
    checks++;
    if (state !== ST_MOVE || moving !== 1'b1 || dir_up !== 1'b1) begin
      failures++; $display("FAIL long_up_start: got state=%0d moving=%0b dir=%0b required 1/1/1", state, moving, dir_up);
    end
    step_n(7);
    checks++;
    if (cur_floor !== 2'd0 || state !== ST_MOVE) begin
      failures++; $display("FAIL long_up_e7: got floor=%0d state=%0d required 0/1", cur_floor, state);
    end
    step();
    checks++;
    if (cur_floor !== 2'd1 || state !== ST_ARRIVE || moving !== 1'b0) begin
      failures++; $display("FAIL long_up_e8: got floor=%0d state=%0d moving=%0b required 1/2/0", cur_floor, state, moving);
    end
    step_n(9);
    checks++;
    if (cur_floor !== 2'd2) begin failures++; $display("FAIL long_up_e17: got floor=%0d required 2", cur_floor); end
    step_n(9);
    checks++;
    if (cur_floor !== 2'd3 || state !== ST_ARRIVE) begin
      failures++; $display("FAIL long_up_e26: got floor=%0d state=%0d required 3/2", cur_floor, state);
    end
    step();
    checks++;
    if (state !== ST_DOOR || ce !== 1'b1 || door_open !== 1'b1) begin
      failures++; $display("FAIL long_up_door: got state=%0d ce=%0b door=%0b required 3/1/1", state, ce, door_open);
    end
    step_n(3);
    checks++;
    if (ce !== 1'b1) begin failures++; $display("FAIL long_up_door_last: got ce=%0b required 1", ce); end
    step();
    checks++;
    if (state !== ST_IDLE || ce !== 1'b0 || door_open !== 1'b0 || calls !== 6'b000000) begin
      failures++; $display("FAIL long_up_idle: got state=%0d ce=%0b door=%0b calls=%06b required 0/0/0/000000",
                           state, ce, door_open, calls);
    end
  endtask

  task automatic test_passing_stop();
    int n;
    do_reset();
    calls = 6'b101000;
    wait_state(ST_DOOR, 60, n);
    checks++;
    if (n != 19 || cur_floor !== 2'd2 || dir_up !== 1'b1) begin
      failures++; $display("FAIL pass_first_stop: got cycles=%0d floor=%0d dir=%0b required 19/2/1", n, cur_floor, dir_up);
    end
    wait_state(ST_MOVE, 20, n);
    checks++;
    if (n != 4 || dir_up !== 1'b1 || calls !== 6'b100000) begin
      failures++; $display("FAIL pass_continue: got cycles=%0d dir=%0b calls=%06b required 4/1/100000", n, dir_up, calls);
    end
    wait_state(ST_DOOR, 20, n);
    checks++;
    if (n != 9 || cur_floor !== 2'd3 || dir_up !== 1'b1) begin
      failures++; $display("FAIL pass_second_stop: got cycles=%0d floor=%0d dir=%0b required 9/3/1", n, cur_floor, dir_up);
    end
    wait_state(ST_IDLE, 20, n);
    checks++;
    if (n != 4) begin failures++; $display("FAIL pass_idle: got cycles=%0d required 4", n); end
  endtask

  task automatic test_reversal();
    calls = 6'b100001;
    step();
    checks++;
    if (state !== ST_DOOR || cur_floor !== 2'd3) begin
      failures++; $display("FAIL rev_door_f3: got state=%0d floor=%0d required 3/3", state, cur_floor);
    end
    step_n(3);
    checks++;
    if (dir_up !== 1'b1 || state !== ST_DOOR) begin
      failures++; $display("FAIL rev_before_flip: got dir=%0b state=%0d required 1/3", dir_up, state);
    end
    step();
    checks++;
    if (dir_up !== 1'b0 || state !== ST_MOVE || ce !== 1'b0) begin
      failures++; $display("FAIL rev_flip: got dir=%0b state=%0d ce=%0b required 0/1/0", dir_up, state, ce);
    end
    step_n(26);
    checks++;
    if (state !== ST_ARRIVE || cur_floor !== 2'd0) begin
      failures++; $display("FAIL rev_arrive_f0: got state=%0d floor=%0d required 2/0", state, cur_floor);
    end
    step();
    checks++;
    if (state !== ST_DOOR || cur_floor !== 2'd0 || ce !== 1'b1) begin
      failures++; $display("FAIL rev_door_f0: got state=%0d floor=%0d ce=%0b required 3/0/1", state, cur_floor, ce);
    end
  endtask

  task automatic test_priority();
    int n;
    do_reset();
    calls = 6'b000010;
    wait_state(ST_DOOR, 30, n);
    wait_state(ST_IDLE, 10, n);
    checks++;
    if (cur_floor !== 2'd1) begin failures++; $display("FAIL prio_park_f1: got floor=%0d required 1", cur_floor); end
    calls = 6'b100001;
    step();
    checks++;
    if (state !== ST_MOVE || dir_up !== 1'b1) begin
      failures++; $display("FAIL prio_up_wins: got state=%0d dir=%0b required 1/1", state, dir_up);
    end
    do_reset();
    calls = 6'b000010;
    wait_state(ST_DOOR, 30, n);
    wait_state(ST_IDLE, 10, n);
    calls = 6'b100101;
    step();
    checks++;
    if (state !== ST_DOOR || cur_floor !== 2'd1) begin
      failures++; $display("FAIL prio_here_first: got state=%0d floor=%0d required 3/1", state, cur_floor);
    end
    step_n(4);
    checks++;
    if (state !== ST_MOVE || dir_up !== 1'b1) begin
      failures++; $display("FAIL prio_continue_up: got state=%0d dir=%0b required 1/1", state, dir_up);
    end
  endtask

  task automatic test_reset_mid_move();
    do_reset();
    calls = 6'b001000;
    step();
    step_n(8);
    checks++;
    if (state !== ST_ARRIVE || cur_floor !== 2'd1) begin
      failures++; $display("FAIL midreset_f1: got state=%0d floor=%0d required 2/1", state, cur_floor);
    end
    step_n(6);
    rst = 1'b1;
    calls = 6'b000000;
    step();
    rst = 1'b0;
    checks++;
    if (cur_floor !== 2'd0 || state !== ST_IDLE || moving !== 1'b0 || dir_up !== 1'b1) begin
      failures++; $display("FAIL midreset: got floor=%0d state=%0d moving=%0b dir=%0b required 0/0/0/1",
                           cur_floor, state, moving, dir_up);
    end
  endtask

`ifdef DOOR_HOLD_EN
  task automatic test_door_hold();
    int open_cnt;
    do_reset();
    calls = 6'b000001;
    step();
    door_hold = 1'b1;
    open_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      step();
      if (door_open === 1'b1 && ce === 1'b1) open_cnt++;
    end
    checks++;
    if (open_cnt != 10) begin failures++; $display("FAIL hold_open: got %0d open cycles required 10", open_cnt); end
    door_hold = 1'b0;
    step_n(3);
    checks++;
    if (door_open !== 1'b1) begin failures++; $display("FAIL hold_release_tail: got door=%0b required 1", door_open); end
    step();
    checks++;
    if (door_open !== 1'b0 || state !== ST_IDLE) begin
      failures++; $display("FAIL hold_close: got door=%0b state=%0d required 0/0", door_open, state);
    end
  endtask
`endif

  initial begin
    checks = 0;
    failures = 0;
    rst = 1'b1;
    calls = 6'b000000;
    door_hold = 1'b0;
    test_reset();
    test_long_up();
    test_passing_stop();
    test_reversal();
    test_priority();
    test_reset_mid_move();
`ifdef DOOR_HOLD_EN
    test_door_hold();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
